// File: rtl/ysyx_23060020_lsu_pkg.sv
// rtl/ysyx_23060020_lsu_pkg.sv - shared LSU types, size codes and XLEN-derived helpers
package ysyx_23060020_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Defaults for the RV32 build; parametrised blocks use the functions below.
    localparam int LSU_XLEN  = 32;
    localparam int LSU_BYTES = LSU_XLEN / 8;
    localparam int LSU_OFFW  = $clog2(LSU_BYTES);

    function automatic int bytes_per_word(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int off_width(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // A dword access on a 32-bit datapath is always illegal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo,
                                           input int xlen);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo[1:0];
            default: bad = (xlen == 32) || (|lo);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_23060020_lsu_if.sv
// rtl/ysyx_23060020_lsu_if.sv - core request/response and data-memory bus bundle
interface ysyx_23060020_lsu_if #(
    parameter int XLEN = 32,
    parameter int AW   = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_wen;
    logic [1:0]          req_size;
    logic                req_signed;
    logic [AW-1:0]       req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic                resp_valid;
    logic                resp_err;
    logic [XLEN-1:0]     resp_rdata;
    logic                mem_valid;
    logic                mem_ready;
    logic                mem_wen;
    logic [AW-1:0]       mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                mem_rsp_valid;
    logic [XLEN-1:0]     mem_rdata;

    // LSU view
    modport slave (
        input  req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        input  mem_ready, mem_rsp_valid, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
    );

    // Core plus memory view
    modport master (
        output req_valid, req_wen, req_size, req_signed, req_addr, req_wdata,
        output mem_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/ysyx_23060020_lsu_align.sv
// rtl/ysyx_23060020_lsu_align.sv - combinational byte-lane steering, strobes and load extension
module ysyx_23060020_lsu_align
    import ysyx_23060020_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BYTES = bytes_per_word(XLEN),
    localparam int OFFW  = off_width(XLEN)
) (
    input  logic [1:0]      size,
    input  logic            sgn,
    input  logic [OFFW-1:0] off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [BYTES-1:0] wstrb,
    output logic [XLEN-1:0] wdata_lanes,
    output logic [XLEN-1:0] rdata_ext
);
    logic [BYTES-1:0] base;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  mask;
    logic             msb;

    // Strobe pattern for the access size moved onto the addressed lanes.
    always_comb begin
        case (size)
            SZ_B:    base = BYTES'(1);
            SZ_H:    base = BYTES'(3);
            SZ_W:    base = BYTES'(15);
            default: base = '1;
        endcase
        wstrb = base << off;
    end

    // Replicating the low bytes puts the data on the addressed lanes for any aligned offset.
    always_comb begin
        wdata_lanes = '0;
        for (int i = 0; i < BYTES; i++) begin
            case (size)
                SZ_B:    wdata_lanes[8*i +: 8] = wdata[7:0];
                SZ_H:    wdata_lanes[8*i +: 8] = wdata[8*(i%2) +: 8];
                SZ_W:    wdata_lanes[8*i +: 8] = wdata[8*(i%4) +: 8];
                default: wdata_lanes[8*i +: 8] = wdata[8*i +: 8];
            endcase
        end
    end

    // Bring the addressed bytes down to bit 0, then sign- or zero-fill above the access size.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (size)
            SZ_B: begin
                mask = XLEN'(8'hFF);
                msb  = shifted[7];
            end
            SZ_H: begin
                mask = XLEN'(16'hFFFF);
                msb  = shifted[15];
            end
            SZ_W: begin
                mask = XLEN'(32'hFFFF_FFFF);
                msb  = shifted[31];
            end
            default: begin
                mask = '1;
                msb  = 1'b0;
            end
        endcase
        rdata_ext = (shifted & mask) | ({XLEN{sgn & msb}} & ~mask);
    end

endmodule

// File: rtl/ysyx_23060020_lsu.sv
// rtl/ysyx_23060020_lsu.sv - multi-cycle load/store unit; LSU_TIMEOUT_EN adds a bus watchdog
module ysyx_23060020_lsu
    import ysyx_23060020_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AW         = 32,
    parameter int TMO_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_23060020_lsu_if.slave bus
);
    localparam int BYTES = bytes_per_word(XLEN);
    localparam int OFFW  = off_width(XLEN);

    lsu_state_e       state_q, state_d;
    logic             wen_q, sgn_q, err_q;
    logic [1:0]       size_q;
    logic [AW-1:0]    addr_q;
    logic [XLEN-1:0]  wdata_q, rdata_q;
    logic             accept, misalign, capture, tmo_fire;
    logic [BYTES-1:0] wstrb;
    logic [XLEN-1:0]  wdata_lanes, rdata_ext;

    assign misalign = is_misaligned(bus.req_size, bus.req_addr[2:0], XLEN);
    assign accept   = (state_q == IDLE) && bus.req_valid;
    assign capture  = (state_q == WAIT) && bus.mem_rsp_valid;

    ysyx_23060020_lsu_align #(.XLEN(XLEN)) u_align (
        .size        (size_q),
        .sgn         (sgn_q),
        .off         (addr_q[OFFW-1:0]),
        .wdata       (wdata_q),
        .rdata       (rdata_q),
        .wstrb       (wstrb),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

`ifdef LSU_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        busy, tmo_hit;

    assign busy    = (state_q == REQ) || (state_q == WAIT);
    assign tmo_hit = busy && (tmo_cnt_q == 16'(TMO_CYCLES - 1));

    // Counts cycles spent in the current REQ or WAIT visit; any state change restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt_q <= '0;
        end else if (busy) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    logic unused_tmo_cycles;
    assign unused_tmo_cycles = ^TMO_CYCLES;
`endif

    // State register; reset drops mem_valid at once and discards any in-flight response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields, captured read data and the error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wen_q   <= bus.req_wen;
                sgn_q   <= bus.req_signed;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                err_q   <= misalign;
            end
            if (capture) begin
                rdata_q <= bus.mem_rdata;
            end
            if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next state and all outputs; outputs are gated by state so idle cycles show zeros.
    always_comb begin
        state_d        = state_q;
        tmo_fire       = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wstrb  = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = misalign ? RESP : REQ;
                end
            end
            REQ: begin
                bus.mem_valid = 1'b1;
                bus.mem_wen   = wen_q;
                bus.mem_addr  = addr_q & ~AW'(BYTES - 1);
                bus.mem_wdata = wen_q ? wdata_lanes : '0;
                bus.mem_wstrb = wen_q ? wstrb : '0;
                if (bus.mem_ready) begin
                    state_d = wen_q ? RESP : WAIT;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d  = RESP;
                    tmo_fire = 1'b1;
                end
`endif
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d  = RESP;
                    tmo_fire = 1'b1;
                end
`endif
            end
            default: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || wen_q) ? '0 : rdata_ext;
                state_d        = IDLE;
            end
        endcase
    end

endmodule
